// File: rtl/vga_pattern_scheduler.sv
// rtl/vga_pattern_scheduler.sv - frame-synchronous test pattern selector for 640x480 VGA
//
// Chooses which test pattern feeds the VGA output. A "next" button or an auto-cycle
// timer advances the selection. The selection only changes at a frame boundary. An
// optional window of forced-black frames follows each switch.
//
// Ports:
//   clk         25 MHz pixel clock, shared with the timing generator
//   clr         asynchronous active-low reset
//   hc, vc      horizontal / vertical counters from the timing generator
//   vidon       active-video flag from the timing generator
//   btn_next    raw button, requests the next pattern
//   btn_mode    raw button, toggles auto / manual mode
//   pattern_sel current pattern index (registered)
//   pixel_en    vidon & ~blank, gates RGB in the top level
//   blank       forced-black window active (registered)
//   auto_mode   1 = auto-cycle mode (registered)
//   frame_tick  one-cycle pulse at frame start (registered)
//   sel_changed one-cycle pulse in the cycle pattern_sel updates
//   frame_cnt   free-running frame counter, wraps 65535 -> 0
module vga_pattern_scheduler #(
  parameter int NUM_PATTERNS = 4,
  parameter int SEL_W        = 2,
  parameter int AUTO_FRAMES  = 60,
  parameter int BLANK_FRAMES = 1,
  parameter int DEB_CYCLES   = 250000
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic             vidon,
  input  logic             btn_next,
  input  logic             btn_mode,
  output logic [SEL_W-1:0] pattern_sel,
  output logic             pixel_en,
  output logic             blank,
  output logic             auto_mode,
  output logic             frame_tick,
  output logic             sel_changed,
  output logic [15:0]      frame_cnt
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int AW = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam int BW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_BLANK = 1'b1
  } state_t;

  // Button path. Bit 0 is next and bit 1 is mode.
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_lvl;
  logic [1:0]    r_lvl_d;
  logic [DW-1:0] r_deb_cnt [2];
  logic [1:0]    w_press;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_lvl   <= '0;
      r_lvl_d <= '0;
      for (int i = 0; i < 2; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1 <= {btn_mode, btn_next};
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < 2; i++) begin
        // Any sample that agrees with the current level restarts the count.
        if (r_sync2[i] == r_lvl[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
          r_lvl[i]     <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_press = r_lvl & ~r_lvl_d;

  // Frame start detection.
  logic        w_at_origin;
  logic        w_frame_start;
  logic        r_prev_origin;
  logic        r_frame_tick;
  logic [15:0] r_frame_cnt;

  assign w_at_origin   = (hc == 10'd0) && (vc == 10'd0);
  assign w_frame_start = w_at_origin && !r_prev_origin;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      // r_prev_origin resets to 1. A reset released while the counters sit at the
      // origin then waits for the next real frame start.
      r_prev_origin <= 1'b1;
      r_frame_tick  <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_prev_origin <= w_at_origin;
      r_frame_tick  <= w_frame_start;
      if (w_frame_start) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Selection state machine. It acts on the registered frame tick.
  state_t           r_state;
  logic [SEL_W-1:0] r_pattern_sel;
  logic             r_pending;
  logic             r_auto_mode;
  logic             r_blank;
  logic             r_sel_changed;
  logic [AW-1:0]    r_auto_cnt;
  logic [BW-1:0]    r_blank_cnt;
  logic             w_switch;

  assign w_switch = r_pending || (r_auto_mode && (r_auto_cnt == AW'(AUTO_FRAMES - 1)));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state       <= S_RUN;
      r_pattern_sel <= '0;
      r_pending     <= 1'b0;
      r_auto_mode   <= 1'b0;
      r_blank       <= 1'b0;
      r_sel_changed <= 1'b0;
      r_auto_cnt    <= '0;
      r_blank_cnt   <= '0;
    end else begin
      r_sel_changed <= 1'b0;
      if (r_frame_tick) begin
        case (r_state)
          S_RUN: begin
            if (w_switch) begin
              r_pattern_sel <= (r_pattern_sel == SEL_W'(NUM_PATTERNS - 1)) ? '0 : r_pattern_sel + 1'b1;
              r_pending     <= 1'b0;
              r_auto_cnt    <= '0;
              r_sel_changed <= 1'b1;
              if (BLANK_FRAMES > 0) begin
                r_blank     <= 1'b1;
                r_blank_cnt <= '0;
                r_state     <= S_BLANK;
              end
            end else if (r_auto_mode) begin
              r_auto_cnt <= r_auto_cnt + 1'b1;
            end
          end
          S_BLANK: begin
            if (r_blank_cnt == BW'(BLANK_FRAMES - 1)) begin
              r_blank <= 1'b0;
              r_state <= S_RUN;
            end else begin
              r_blank_cnt <= r_blank_cnt + 1'b1;
            end
          end
          default: r_state <= S_RUN;
        endcase
      end
      // These come after the frame-tick update so they win in a shared cycle. A next
      // press in a tick cycle is kept for the following frame. A mode press always
      // restarts the auto timer.
      if (w_press[0]) r_pending <= 1'b1;
      if (w_press[1]) begin
        r_auto_mode <= ~r_auto_mode;
        r_auto_cnt  <= '0;
      end
    end
  end

  assign pattern_sel = r_pattern_sel;
  assign blank       = r_blank;
  assign auto_mode   = r_auto_mode;
  assign frame_tick  = r_frame_tick;
  assign sel_changed = r_sel_changed;
  assign frame_cnt   = r_frame_cnt;
  assign pixel_en    = vidon & ~r_blank;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// tb/tb_vga_pattern_scheduler.sv - randomized self-checking bench for vga_pattern_scheduler
module tb_vga_pattern_scheduler;

  localparam int H  = 20;
  localparam int V  = 10;
  localparam int F  = H * V;
  localparam int NP = 4;
  localparam int AF = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       vidon;
  logic       btn_next;
  logic       btn_mode;

  logic [1:0]  sel_a, sel_b;
  logic        pix_a, pix_b, blank_a, blank_b, auto_a, auto_b;
  logic        tick_a, tick_b, sc_a, sc_b;
  logic [15:0] fcnt_a, fcnt_b;

  always #20 clk = ~clk;

  vga_pattern_scheduler #(.NUM_PATTERNS(NP), .SEL_W(2), .AUTO_FRAMES(AF), .BLANK_FRAMES(0), .DEB_CYCLES(4)) u_dut_a (
    .clk(clk), .clr(clr), .hc(hc), .vc(vc), .vidon(vidon), .btn_next(btn_next), .btn_mode(btn_mode),
    .pattern_sel(sel_a), .pixel_en(pix_a), .blank(blank_a), .auto_mode(auto_a),
    .frame_tick(tick_a), .sel_changed(sc_a), .frame_cnt(fcnt_a));

  vga_pattern_scheduler #(.NUM_PATTERNS(NP), .SEL_W(2), .AUTO_FRAMES(AF), .BLANK_FRAMES(2), .DEB_CYCLES(4)) u_dut_b (
    .clk(clk), .clr(clr), .hc(hc), .vc(vc), .vidon(vidon), .btn_next(btn_next), .btn_mode(btn_mode),
    .pattern_sel(sel_b), .pixel_en(pix_b), .blank(blank_b), .auto_mode(auto_b),
    .frame_tick(tick_b), .sel_changed(sc_b), .frame_cnt(fcnt_b));

  int n_chk = 0;
  int n_err = 0;
  int frame_idx = -1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s frame=%0d: got %0d expected %0d", tag, frame_idx, obs, exp);
    end
  endtask

  // Frame-level reference model. Index 0 = no blanking, 1 = two blank frames.
  int m_bf    [2] = '{0, 2};
  int m_sel   [2];
  int m_pend  [2];
  int m_auto  [2];
  int m_acnt  [2];
  int m_blank [2];
  int m_bleft [2];
  int m_fcnt  [2];
  int m_sw    [2];

  // Button schedule for the current frame, with the press counts it contains.
  bit s_next [0:F-1];
  bit s_mode [0:F-1];
  int f_next;
  int f_mode;
  int lead_next = 0;

  task automatic clear_sched();
    for (int p = 0; p < F; p++) begin
      s_next[p] = 1'b0;
      s_mode[p] = 1'b0;
    end
    f_next = (lead_next > 0) ? 1 : 0;
    f_mode = 0;
  endtask

  task automatic put_press(input int slot, input bit is_mode);
    for (int k = 0; k < 8; k++) begin
      if (is_mode) s_mode[10 + 16 * slot + k] = 1'b1;
      else         s_next[10 + 16 * slot + k] = 1'b1;
    end
    if (is_mode) f_mode++;
    else         f_next++;
  endtask

  task automatic put_glitch(input int slot);
    s_next[10 + 16 * slot]     = 1'b1;
    s_next[10 + 16 * slot + 1] = 1'b1;
  endtask

  task automatic build_rand();
    clear_sched();
    if ($urandom_range(0, 4) == 0) put_press(0, 1'b1);
    for (int s = 1; s < 8; s++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r == 0)      put_press(s, 1'b0);
      else if (r == 1) put_glitch(s);
    end
  endtask

  task automatic model_tick();
    for (int d = 0; d < 2; d++) begin
      m_fcnt[d] = (m_fcnt[d] + 1) % 65536;
      m_sw[d] = 0;
      if (m_blank[d] == 0) begin
        if (m_pend[d] != 0 || (m_auto[d] != 0 && m_acnt[d] == AF - 1)) begin
          m_sel[d]  = (m_sel[d] + 1) % NP;
          m_pend[d] = 0;
          m_acnt[d] = 0;
          m_sw[d]   = 1;
          if (m_bf[d] > 0) begin
            m_blank[d] = 1;
            m_bleft[d] = m_bf[d];
          end
        end else if (m_auto[d] != 0) begin
          m_acnt[d]++;
        end
      end else begin
        m_bleft[d]--;
        if (m_bleft[d] == 0) m_blank[d] = 0;
      end
    end
  endtask

  task automatic drive_pos(input int p);
    hc    = 10'(p % H);
    vc    = 10'(p / H);
    vidon = ((p % H) < 16) && ((p / H) < 8);
    @(negedge clk);
  endtask

  task automatic run_frame();
    int ta, tb, ca, cb;
    frame_idx++;
    model_tick();
    ta = 0; tb = 0; ca = 0; cb = 0;
    for (int p = 0; p < F; p++) begin
      btn_next = s_next[p] || (p < lead_next);
      btn_mode = s_mode[p];
      drive_pos(p);
      if (tick_a) ta++;
      if (tick_b) tb++;
      if (sc_a) ca++;
      if (sc_b) cb++;
      if (p == 0) begin
        check_val("a.tick_at_origin", 32'(tick_a), 1);
        check_val("b.tick_at_origin", 32'(tick_b), 1);
      end
      if (p == 5) begin
        check_val("a.sel",   32'(sel_a),   m_sel[0]);
        check_val("b.sel",   32'(sel_b),   m_sel[1]);
        check_val("a.blank", 32'(blank_a), m_blank[0]);
        check_val("b.blank", 32'(blank_b), m_blank[1]);
        check_val("a.auto",  32'(auto_a),  m_auto[0]);
        check_val("b.auto",  32'(auto_b),  m_auto[1]);
        check_val("a.fcnt",  32'(fcnt_a),  m_fcnt[0]);
        check_val("b.fcnt",  32'(fcnt_b),  m_fcnt[1]);
        check_val("a.pix_vid", 32'(pix_a), (m_blank[0] == 0) ? 1 : 0);
        check_val("b.pix_vid", 32'(pix_b), (m_blank[1] == 0) ? 1 : 0);
      end
      if (p == 18) begin
        check_val("a.pix_hblank", 32'(pix_a), 0);
        check_val("b.pix_hblank", 32'(pix_b), 0);
      end
    end
    check_val("a.ticks_per_frame", 32'(ta), 1);
    check_val("b.ticks_per_frame", 32'(tb), 1);
    check_val("a.sel_changed_cnt", 32'(ca), m_sw[0]);
    check_val("b.sel_changed_cnt", 32'(cb), m_sw[1]);
    // Presses made during this frame take effect at the next frame tick.
    for (int d = 0; d < 2; d++) begin
      if (f_next > 0) m_pend[d] = 1;
      if (f_mode % 2 == 1) m_auto[d] = 1 - m_auto[d];
      if (f_mode > 0) m_acnt[d] = 0;
    end
  endtask

  initial begin
    int ta, tb;
    for (int d = 0; d < 2; d++) begin
      m_sel[d] = 0; m_pend[d] = 0; m_auto[d] = 0; m_acnt[d] = 0;
      m_blank[d] = 0; m_bleft[d] = 0; m_fcnt[d] = 0; m_sw[d] = 0;
    end
    clr = 1'b0; hc = 10'd300; vc = 10'd200; vidon = 1'b0;
    btn_next = 1'b0; btn_mode = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (3) @(negedge clk);
    check_val("a.rst_sel",   32'(sel_a),   0);
    check_val("b.rst_sel",   32'(sel_b),   0);
    check_val("a.rst_blank", 32'(blank_a), 0);
    check_val("b.rst_blank", 32'(blank_b), 0);
    check_val("a.rst_auto",  32'(auto_a),  0);
    check_val("a.rst_tick",  32'(tick_a),  0);
    check_val("a.rst_sc",    32'(sc_a),    0);
    check_val("a.rst_fcnt",  32'(fcnt_a),  0);
    check_val("b.rst_fcnt",  32'(fcnt_b),  0);

    // Finish the frame that was in progress at reset release. No tick is expected.
    ta = 0; tb = 0;
    for (int p = 150; p < F; p++) begin
      drive_pos(p);
      if (tick_a) ta++;
      if (tick_b) tb++;
    end
    check_val("a.no_tick_midframe", 32'(ta), 0);
    check_val("b.no_tick_midframe", 32'(tb), 0);

    // Turn auto mode on, then let it cycle through the full pattern wrap.
    clear_sched(); put_press(0, 1'b1); run_frame();
    for (int k = 0; k < 12; k++) begin clear_sched(); run_frame(); end
    // Single press, triple press in one frame, then a glitch only.
    clear_sched(); put_press(2, 1'b0); run_frame();
    clear_sched(); put_press(1, 1'b0); put_press(3, 1'b0); put_press(5, 1'b0); run_frame();
    clear_sched(); put_glitch(2); run_frame();
    // This press becomes a pulse in the same cycle as the next frame tick.
    clear_sched();
    for (int p = F - 5; p < F; p++) s_next[p] = 1'b1;
    run_frame();
    lead_next = 5;
    clear_sched(); run_frame();
    lead_next = 0;
    for (int k = 0; k < 40; k++) begin build_rand(); run_frame(); end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_pattern_scheduler.md
Name: vga_pattern_scheduler

Overview:
Frame-synchronous controller that decides which test pattern drives the 640x480 VGA output.
- Watches the timing generator's hc/vc/vidon and debounces two board buttons.
- Advances the pattern select on manual request or an auto-cycle timer, and only ever changes it at a frame boundary.
- Optionally forces black output for a number of frames after each switch.
- Outputs feed the pattern-generator mux and the RGB gating in the top level.

Parameters:
- NUM_PATTERNS, 4, number of selectable patterns; select wraps NUM_PATTERNS-1 -> 0.
- SEL_W, 2, width of pattern_sel; must satisfy 2^SEL_W >= NUM_PATTERNS.
- AUTO_FRAMES, 60, frames per pattern in auto mode (>=1).
- BLANK_FRAMES, 1, frames of forced black after a switch (0 disables blanking).
- DEB_CYCLES, 250000, consecutive stable clk samples required to accept a button level (10 ms at 25 MHz).

Ports:
- clk, in, 1, 25 MHz pixel clock (same clock as the timing generator).
- clr, in, 1, asynchronous active-low reset.
- hc, in, 10, horizontal counter from the timing generator.
- vc, in, 10, vertical counter from the timing generator.
- vidon, in, 1, active-video flag from the timing generator.
- btn_next, in, 1, raw button: request next pattern.
- btn_mode, in, 1, raw button: toggle auto/manual mode.
- pattern_sel, out, SEL_W, current pattern index.
- pixel_en, out, 1, vidon & ~blank; RGB is driven to 0 when low.
- blank, out, 1, forced-black window active.
- auto_mode, out, 1, 1 = auto-cycle mode.
- frame_tick, out, 1, one-cycle pulse at frame start.
- sel_changed, out, 1, one-cycle pulse in the cycle pattern_sel updates.
- frame_cnt, out, 16, free-running frame counter; wraps at 65535 -> 0.

Behaviour:
- Reset (clr=0, async):
  - Outputs: pattern_sel=0, blank=0, auto_mode=0, frame_tick=0, sel_changed=0, frame_cnt=0.
  - Internal: pending=0, auto_cnt=0, blank_cnt=0, debounced levels=0, state=RUN.
  - Release mid-frame: no frame_tick fires until the next (hc,vc)=(0,0).
- Button inputs:
  - Each button passes through a 2-flop synchronizer and then a debounce counter.
  - The debounced level updates after DEB_CYCLES consecutive samples that differ from the current level; any bounce restarts the count.
  - A rising edge of the debounced level gives a one-cycle press pulse.
- frame_tick:
  - Registered. Asserts for one cycle, on the cycle after the first clk where hc==0 and vc==0 following any cycle with (hc,vc)!=(0,0).
  - A stalled counter at (0,0) yields a single tick.
  - frame_cnt increments on every frame_tick.
- next press: sets the sticky pending flag. Multiple presses before a frame_tick collapse to one advance.
- mode press: toggles auto_mode on the next clk and clears auto_cnt. pending is unaffected.
- State RUN, on each frame_tick:
  - The switch condition is pending=1, or auto_mode=1 and auto_cnt==AUTO_FRAMES-1.
  - If the switch condition holds: pattern_sel <= (pattern_sel==NUM_PATTERNS-1) ? 0 : pattern_sel+1. Also pending <= 0, auto_cnt <= 0, sel_changed pulses.
  - After a switch: if BLANK_FRAMES>0, blank <= 1, blank_cnt <= 0, go to BLANK. Otherwise stay in RUN.
  - If there is no switch and auto_mode=1, auto_cnt increments. In manual mode auto_cnt holds at 0.
- State BLANK, on each frame_tick:
  - blank_cnt increments.
  - When blank_cnt reaches BLANK_FRAMES-1, blank <= 0 and the block returns to RUN.
  - auto_cnt is frozen.
  - Presses during BLANK set pending, which is applied at the first frame_tick in RUN after the return.
- Simultaneous events:
  - A next press in the same cycle as frame_tick is latched as pending and applied at the following frame_tick, not the current one.
  - A mode press in the same cycle as an auto switch: the switch happens and auto_mode toggles.
- pattern_sel, blank and auto_mode are registered. pixel_en is combinational from vidon and registered blank.
- Net effect: pattern_sel changes only at frame start, so no mid-frame tearing.

Test Plan:
1. Reset mid-frame, then release with hc=300, vc=200 -> pattern_sel=0, blank=0, frame_tick=0. First frame_tick comes one cycle after hc=vc=0; frame_cnt=1.
2. With DEB_CYCLES=4 and BLANK_FRAMES=0, press btn_next once mid-frame -> pattern_sel stays 0 until the next frame_tick, then becomes 1 with one sel_changed pulse.
3. Press btn_next three times within one frame -> only a single advance (0->1) at the next frame_tick.
4. A 2-cycle glitch on btn_next with DEB_CYCLES=4 -> no pending and no advance.
5. With AUTO_FRAMES=3, BLANK_FRAMES=0 and auto mode on -> sequence 0,1,2,3,0 advancing every 3 frame_ticks; the wrap 3->0 is checked.
6. With BLANK_FRAMES=2, advance once -> blank=1 and pixel_en=0 for exactly 2 frames. A press during blank is applied at the first frame_tick after blank drops.
